// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch : instruction fetch stage with IF/ID pipeline register and an
// optional branch history table.
//
// Optional feature macro: BRANCH_PREDICT_EN
//   defined   -> BHT_ENTRIES-entry predictor {valid, 2-bit counter, target}
//   undefined -> no predictor storage, prediction always not-taken
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   imem_req            fetch request, high whenever out of reset
//   imem_addr           fetch address (current PC)
//   imem_ready/rdata    instruction memory response, valid when ready=1
//   id_stall            decode hold request
//   id_force_jump/next  decode-resolved jump and its target
//   ex_mispredict/pc    execute redirect after branch misprediction
//   ex_br_*             resolved-branch predictor update
//   inst, if_pc         IF/ID register: instruction word and its PC
//   if_branch_taken     IF/ID register: instruction was predicted taken
//   if_valid            IF/ID register holds a real instruction
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        id_force_jump,
  input  logic [31:0] id_next_pc,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_br_update,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_pc,
  input  logic [31:0] ex_br_target,
  output logic [31:0] inst,
  output logic [31:0] if_pc,
  output logic        if_branch_taken,
  output logic        if_valid
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        bt_q, bt_d;
  logic        valid_q, valid_d;

  logic        pred_taken;
  logic [31:0] pred_tgt;

`ifdef BRANCH_PREDICT_EN
  logic             bht_valid_q [BHT_ENTRIES];
  logic [1:0]       bht_ctr_q   [BHT_ENTRIES];
  logic [31:0]      bht_tgt_q   [BHT_ENTRIES];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             unused_bits;

  assign rd_idx = pc_q[IDX_W+1:2];
  assign wr_idx = ex_br_pc[IDX_W+1:2];
  assign unused_bits = ^{ex_br_pc[31:IDX_W+2], ex_br_pc[1:0]};

  // Lookup reads registered state, so a same-cycle update to the same
  // index is only visible from the next cycle on.
  assign pred_taken = bht_valid_q[rd_idx] && bht_ctr_q[rd_idx][1];
  assign pred_tgt   = bht_tgt_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_valid_q[i] <= 1'b0;
        bht_ctr_q[i]   <= 2'b01;
        bht_tgt_q[i]   <= '0;
      end
    end else if (ex_br_update) begin
      bht_valid_q[wr_idx] <= 1'b1;
      bht_tgt_q[wr_idx]   <= ex_br_target;
      if (ex_br_taken) begin
        if (bht_ctr_q[wr_idx] != 2'b11) bht_ctr_q[wr_idx] <= bht_ctr_q[wr_idx] + 2'd1;
      end else begin
        if (bht_ctr_q[wr_idx] != 2'b00) bht_ctr_q[wr_idx] <= bht_ctr_q[wr_idx] - 2'd1;
      end
    end
  end
`else
  logic        unused_bits;
  logic [31:0] unused_cfg;

  assign pred_taken  = 1'b0;
  assign pred_tgt    = '0;
  assign unused_cfg  = 32'(BHT_ENTRIES) ^ 32'(IDX_W);
  assign unused_bits = ^{ex_br_update, ex_br_taken, ex_br_pc, ex_br_target, unused_cfg};
`endif

  // Next PC and IF/ID contents share one priority chain.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    if_pc_d = if_pc_q;
    bt_d    = bt_q;
    valid_d = valid_q;
    if (ex_mispredict) begin
      pc_d    = ex_redirect_pc;
      inst_d  = '0;
      if_pc_d = pc_q;
      bt_d    = 1'b0;
      valid_d = 1'b0;
    end else if (id_force_jump && !id_stall) begin
      pc_d    = id_next_pc;
      inst_d  = '0;
      if_pc_d = pc_q;
      bt_d    = 1'b0;
      valid_d = 1'b0;
    end else if (id_stall) begin
      pc_d = pc_q;
    end else if (!imem_ready) begin
      inst_d  = '0;
      if_pc_d = pc_q;
      bt_d    = 1'b0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pred_taken ? pred_tgt : pc_q + 32'd4;
      inst_d  = imem_rdata;
      if_pc_d = pc_q;
      bt_d    = pred_taken;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      if_pc_q <= RESET_PC;
      bt_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      if_pc_q <= if_pc_d;
      bt_q    <= bt_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req        = rst_n;
  assign imem_addr       = pc_q;
  assign inst            = inst_q;
  assign if_pc           = if_pc_q;
  assign if_branch_taken = bt_q;
  assign if_valid        = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch : self-checking bench for inst_fetch. Per-cycle stimulus
// records carry the expected post-edge outputs; expectations pass through a
// scoreboard queue and are compared one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

`ifdef BRANCH_PREDICT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        id_stall = 1'b0;
  logic        id_force_jump = 1'b0;
  logic [31:0] id_next_pc = '0;
  logic        ex_mispredict = 1'b0;
  logic [31:0] ex_redirect_pc = '0;
  logic        ex_br_update = 1'b0;
  logic        ex_br_taken = 1'b0;
  logic [31:0] ex_br_pc = '0;
  logic [31:0] ex_br_target = '0;
  logic [31:0] inst;
  logic [31:0] if_pc;
  logic        if_branch_taken;
  logic        if_valid;

  always #5 clk = ~clk;

  // Memory model: content depends on address; garbage when not ready.
  assign imem_rdata = imem_ready ? w(imem_addr) : 32'hBAD0_BAD0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .BHT_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .id_force_jump(id_force_jump), .id_next_pc(id_next_pc),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .ex_br_update(ex_br_update), .ex_br_taken(ex_br_taken),
    .ex_br_pc(ex_br_pc), .ex_br_target(ex_br_target),
    .inst(inst), .if_pc(if_pc), .if_branch_taken(if_branch_taken), .if_valid(if_valid)
  );

  typedef struct {
    logic        st, fj, mis, rdy, bu, btk;
    logic [31:0] npc, rpc, bpc, btgt;
    logic [31:0] e_addr, e_inst, e_pc;
    logic        e_bt, e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] a, i, p;
    logic        bt, v;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic st, input logic fj, input logic [31:0] npc,
                              input logic mis, input logic [31:0] rpc, input logic rdy,
                              input logic [31:0] a, input logic [31:0] ins,
                              input logic [31:0] p, input logic val);
    vec_t v;
    v.st = st; v.fj = fj; v.npc = npc; v.mis = mis; v.rpc = rpc; v.rdy = rdy;
    v.bu = 1'b0; v.btk = 1'b0; v.bpc = '0; v.btgt = '0;
    v.e_addr = a; v.e_inst = ins; v.e_pc = p; v.e_bt = 1'b0; v.e_valid = val;
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    exp_t e, g;
    id_stall = v.st; id_force_jump = v.fj; id_next_pc = v.npc;
    ex_mispredict = v.mis; ex_redirect_pc = v.rpc; imem_ready = v.rdy;
    ex_br_update = v.bu; ex_br_taken = v.btk; ex_br_pc = v.bpc; ex_br_target = v.btgt;
    e = '{a: v.e_addr, i: v.e_inst, p: v.e_pc, bt: v.e_bt, v: v.e_valid};
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty got 0 expected 1 entry", nm);
    end else begin
      g = sb.pop_front();
      chk({nm, ".addr"},  imem_addr, g.a);
      chk({nm, ".inst"},  inst, g.i);
      chk({nm, ".if_pc"}, if_pc, g.p);
      chk({nm, ".bt"},    {31'b0, if_branch_taken}, {31'b0, g.bt});
      chk({nm, ".valid"}, {31'b0, if_valid}, {31'b0, g.v});
    end
  endtask

  vec_t vecs[28];
  vec_t v;

  initial begin
    // ------------------------------------------------------------------ table
    //            st   fj   npc            mis  rpc            rdy  addr           inst               if_pc          val
    vecs[0]  = mk(0,   0,   '0,            0,   '0,            1,   32'h4,         w(32'h0),          32'h0,         1);
    vecs[1]  = mk(0,   0,   '0,            0,   '0,            1,   32'h8,         w(32'h4),          32'h4,         1);
    vecs[2]  = mk(0,   0,   '0,            0,   '0,            1,   32'hC,         w(32'h8),          32'h8,         1);
    vecs[3]  = mk(0,   0,   '0,            0,   '0,            1,   32'h10,        w(32'hC),          32'hC,         1);
    vecs[4]  = mk(1,   0,   '0,            0,   '0,            1,   32'h10,        w(32'hC),          32'hC,         1);
    vecs[5]  = mk(1,   0,   '0,            0,   '0,            1,   32'h10,        w(32'hC),          32'hC,         1);
    vecs[6]  = mk(1,   0,   '0,            0,   '0,            1,   32'h10,        w(32'hC),          32'hC,         1);
    vecs[7]  = mk(0,   0,   '0,            0,   '0,            1,   32'h14,        w(32'h10),         32'h10,        1);
    vecs[8]  = mk(0,   0,   '0,            0,   '0,            1,   32'h18,        w(32'h14),         32'h14,        1);
    vecs[9]  = mk(0,   0,   '0,            0,   '0,            1,   32'h1C,        w(32'h18),         32'h18,        1);
    vecs[10] = mk(0,   0,   '0,            0,   '0,            1,   32'h20,        w(32'h1C),         32'h1C,        1);
    vecs[11] = mk(0,   1,   32'h400,       0,   '0,            1,   32'h400,       32'h0,             32'h20,        0);
    vecs[12] = mk(0,   0,   '0,            0,   '0,            1,   32'h404,       w(32'h400),        32'h400,       1);
    vecs[13] = mk(1,   0,   '0,            1,   32'h80,        1,   32'h80,        32'h0,             32'h404,       0);
    vecs[14] = mk(0,   0,   '0,            0,   '0,            1,   32'h84,        w(32'h80),         32'h80,        1);
    vecs[15] = mk(0,   0,   '0,            0,   '0,            0,   32'h84,        32'h0,             32'h84,        0);
    vecs[16] = mk(0,   0,   '0,            0,   '0,            0,   32'h84,        32'h0,             32'h84,        0);
    vecs[17] = mk(0,   0,   '0,            0,   '0,            1,   32'h88,        w(32'h84),         32'h84,        1);
    vecs[18] = mk(0,   0,   '0,            0,   '0,            1,   32'h8C,        w(32'h88),         32'h88,        1);
    vecs[19] = mk(1,   1,   32'h999C,      0,   '0,            1,   32'h8C,        w(32'h88),         32'h88,        1);
    vecs[20] = mk(0,   1,   32'h200,       0,   '0,            1,   32'h200,       32'h0,             32'h8C,        0);
    vecs[21] = mk(0,   0,   '0,            0,   '0,            1,   32'h204,       w(32'h200),        32'h200,       1);
    vecs[22] = mk(0,   1,   32'h500,       1,   32'h300,       1,   32'h300,       32'h0,             32'h204,       0);
    vecs[23] = mk(0,   0,   '0,            0,   '0,            1,   32'h304,       w(32'h300),        32'h300,       1);
    vecs[24] = mk(1,   0,   '0,            0,   '0,            0,   32'h304,       w(32'h300),        32'h300,       1);
    vecs[25] = mk(0,   0,   '0,            0,   '0,            1,   32'h308,       w(32'h304),        32'h304,       1);
    vecs[26] = mk(0,   0,   '0,            1,   32'hFFFF_FFFC, 1,   32'hFFFF_FFFC, 32'h0,             32'h308,       0);
    vecs[27] = mk(0,   0,   '0,            0,   '0,            1,   32'h0,         w(32'hFFFF_FFFC),  32'hFFFF_FFFC, 1);

    // ------------------------------------------------------------------ reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req_low", {31'b0, imem_req}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.req",   {31'b0, imem_req}, 32'h1);
    chk("rst.inst",  inst, 32'h0);
    chk("rst.if_pc", if_pc, 32'h0);
    chk("rst.valid", {31'b0, if_valid}, 32'h0);
    chk("rst.bt",    {31'b0, if_branch_taken}, 32'h0);

    for (int i = 0; i < 28; i++) step(vecs[i], $sformatf("vec%0d", i));

    // ------------------------------------------- predictor training, PC now 0
    v = mk(0, 0, '0, 0, '0, 1, 32'h4, w(32'h0), 32'h0, 1);
    v.bu = 1'b1; v.btk = 1'b1; v.bpc = 32'h40; v.btgt = 32'h100;
    step(v, "bht.upd1");
    v = mk(0, 0, '0, 0, '0, 1, 32'h8, w(32'h4), 32'h4, 1);
    v.bu = 1'b1; v.btk = 1'b1; v.bpc = 32'h40; v.btgt = 32'h100;
    step(v, "bht.upd2");
    step(mk(0, 0, '0, 1, 32'h40, 1, 32'h40, 32'h0, 32'h8, 0), "bht.redir");
    v = mk(0, 0, '0, 0, '0, 1, BP ? 32'h100 : 32'h44, w(32'h40), 32'h40, 1);
    v.e_bt = BP;
    step(v, "bht.fetch40");

    // ---------------------------------------- asynchronous reset mid-cycle
    #2;
    imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst.addr",  imem_addr, 32'h0);
    chk("arst.inst",  inst, 32'h0);
    chk("arst.if_pc", if_pc, 32'h0);
    chk("arst.valid", {31'b0, if_valid}, 32'h0);
    chk("arst.bt",    {31'b0, if_branch_taken}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, '0, 0, '0, 1, 32'h4, w(32'h0), 32'h0, 1), "arst.first");
    step(mk(0, 0, '0, 1, 32'h40, 1, 32'h40, 32'h0, 32'h4, 0), "arst.redir");
    // Predictor state was cleared by reset, so 0x40 falls through.
    step(mk(0, 0, '0, 0, '0, 1, 32'h44, w(32'h40), 32'h40, 1), "arst.fetch40");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
